// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
// slave is the arbiter's view; master is the core/memory side driving it.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ack;

  logic                  d_req;
  logic [3:0]            d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_ack;

  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  logic                  stall_if;
  logic                  stall_d;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, d_rdata, d_ack,
    output mem_req, mem_addr, mem_we, mem_wdata, stall_if, stall_d
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, d_rdata, d_ack,
    input  mem_req, mem_addr, mem_we, mem_wdata, stall_if, stall_d
  );

endinterface

// File: rtl/mem_port_arbiter_prio.sv
// Winner select between fetch and data, with the data-streak counter that
// bounds how long a waiting fetch can be starved.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_BURST = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   grant_en,
  input  logic   i_req,
  input  logic   d_req,
  output logic   grant_vld,
  output owner_t grant_own
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_D_BURST);

  logic [3:0] streak_q;
  logic [3:0] streak_d;

  // Data wins unless fetch is waiting and data has used up its streak.
  always_comb begin
    grant_vld = grant_en & (i_req | d_req);
    if (d_req && (!i_req || (streak_q != BURST_MAX))) begin
      grant_own = OWN_D;
    end else begin
      grant_own = OWN_I;
    end
  end

  // Streak counts data grants that overtook a waiting fetch.
  always_comb begin
    streak_d = streak_q;
    if (grant_vld) begin
      if ((grant_own == OWN_I) || !i_req) begin
        streak_d = '0;
      end else if (streak_q < BURST_MAX) begin
        streak_d = streak_q + 4'd1;
      end
    end
  end

  // Streak register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences one single-ported memory between instruction fetch and data
// access, one transaction at a time, with registered memory handshakes.
//
// state   | meaning
// IDLE    | no transaction outstanding; arbitrate and launch on a request
// SERVE_I | fetch transaction on the memory bus, waiting for mem_ready
// SERVE_D | data transaction on the memory bus, waiting for mem_ready
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int unsigned MAX_D_BURST = 3
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_SERVE_I = SERVE_I;
  localparam logic [1:0] ST_SERVE_D = SERVE_D;

  logic [1:0]            state_q,     state_d;
  logic                  mem_req_q,   mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [3:0]            mem_we_q,    mem_we_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q,   d_rdata_d;
  logic                  if_ack_q,    if_ack_d;
  logic                  d_ack_q,     d_ack_d;

  logic   grant_en;
  logic   grant_vld;
  owner_t grant_own;

  assign grant_en = (state_q == ST_IDLE);

  // A requester still holding req in its ack cycle is asking for its next
  // transaction, so the raw requests feed arbitration directly.
  mem_arb_prio #(
    .MAX_D_BURST (MAX_D_BURST)
  ) u_prio (
    .clk       (clk),
    .rst_n     (rst_n),
    .grant_en  (grant_en),
    .i_req     (bus.if_req),
    .d_req     (bus.d_req),
    .grant_vld (grant_vld),
    .grant_own (grant_own)
  );

  // Launch on grant, hold the memory bus until ready, then pulse the ack.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          mem_req_d = 1'b1;
          if (grant_own == OWN_D) begin
            mem_addr_d  = bus.d_addr;
            mem_we_d    = bus.d_we;
            mem_wdata_d = bus.d_wdata;
            state_d     = ST_SERVE_D;
          end else begin
            mem_addr_d  = bus.if_addr;
            mem_we_d    = WE_NONE;
            mem_wdata_d = '0;
            state_d     = ST_SERVE_I;
          end
        end
      end
      ST_SERVE_I: begin
        if (bus.mem_ready) begin
          mem_req_d  = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = bus.mem_rdata;
          state_d    = ST_IDLE;
        end
      end
      ST_SERVE_D: begin
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          d_ack_d   = 1'b1;
          if (mem_we_q == WE_NONE) begin
            d_rdata_d = bus.mem_rdata;
          end
          state_d = ST_IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.stall_if  = bus.if_req & ~if_ack_q;
  assign bus.stall_d   = bus.d_req & ~d_ack_q;

endmodule
